// File: rtl/atomic_counter_bank_if.sv
// CSR-style read port of the atomic counter bank.
// Signal names are given from the slave (counter bank) side.
interface atomic_counter_bank_if #(
  parameter int SEL_W = 2,
  parameter int WRD_W = 1,
  parameter int BUS_W = 32
);
  logic             req_i;
  logic             atomic_i;
  logic [SEL_W-1:0] sel_i;
  logic [WRD_W-1:0] word_i;
  logic             ack_o;
  logic             err_o;
  logic [BUS_W-1:0] count_o;

  modport master (output req_i, atomic_i, sel_i, word_i, input ack_o, err_o, count_o);
  modport slave  (input req_i, atomic_i, sel_i, word_i, output ack_o, err_o, count_o);
endinterface

// File: rtl/atomic_counter_bank.sv
// Bank of free-running event counters read word-by-word, with atomic snapshot of upper words.
// Optional macro ATOMIC_CNT_CLR_ON_READ_EN: a legal atomic read also clears the counter.
module acb_lane #(
  parameter int CNT_W = 64,
  parameter int BUS_W = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 trig_i,
  input  logic                                 snap_i,
  output logic [CNT_W/BUS_W-1:0][BUS_W-1:0]    wrd_o
);
  localparam int NUM_WORDS = CNT_W / BUS_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(trig_i);
`ifdef ATOMIC_CNT_CLR_ON_READ_EN
    // Restart from the concurrent event so it is not lost.
    if (snap_i) cnt_d = CNT_W'(trig_i);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  generate
    if (NUM_WORDS > 1) begin : g_shd
      logic [CNT_W-BUS_W-1:0] shd_q;
      always_ff @(posedge clk) begin
        if (!reset_n)    shd_q <= '0;
        else if (snap_i) shd_q <= cnt_q[CNT_W-1:BUS_W];
      end
      // Word 0 is always live; upper words come only from the snapshot.
      assign wrd_o = {shd_q, cnt_q[BUS_W-1:0]};
    end else begin : g_noshd
      assign wrd_o = cnt_q;
    end
  endgenerate
endmodule

module atomic_counter_bank #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int BUS_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_CNT-1:0] trig_i,
  atomic_counter_bank_if.slave bus
);
  localparam int NUM_WORDS = CNT_W / BUS_W;
  localparam int SEL_W     = (NUM_CNT   > 1) ? $clog2(NUM_CNT)   : 1;
  localparam int WRD_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [SEL_W:0] NCNT = (SEL_W+1)'(NUM_CNT);
  localparam logic [WRD_W:0] NWRD = (WRD_W+1)'(NUM_WORDS);

  logic [NUM_CNT-1:0][NUM_WORDS-1:0][BUS_W-1:0] wrd;
  logic [NUM_CNT-1:0]                           snap;
  logic                                         legal;
  logic [BUS_W-1:0]                             rd_d;
  logic                                         ack_q, ack_d, err_q, err_d;
  logic [BUS_W-1:0]                             count_q, count_d;

  for (genvar c = 0; c < NUM_CNT; c++) begin : g_lane
    acb_lane #(.CNT_W(CNT_W), .BUS_W(BUS_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .trig_i  (trig_i[c]),
      .snap_i  (snap[c]),
      .wrd_o   (wrd[c])
    );
  end

  always_comb begin
    legal = ({1'b0, bus.sel_i} < NCNT) && ({1'b0, bus.word_i} < NWRD) &&
            !(bus.atomic_i && (bus.word_i != '0));
    rd_d  = '0;
    snap  = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      if (bus.sel_i == SEL_W'(c)) begin
        for (int w = 0; w < NUM_WORDS; w++)
          if (bus.word_i == WRD_W'(w)) rd_d = wrd[c][w];
        snap[c] = bus.req_i && bus.atomic_i && legal;
      end
    end
    ack_d   = bus.req_i;
    err_d   = bus.req_i && !legal;
    count_d = (bus.req_i && legal) ? rd_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_atomic_counter_bank.sv
// Bench for atomic_counter_bank: default build checked against a behavioural model every cycle,
// plus a small NUM_CNT=5, CNT_W=12, BUS_W=4 build for carry, wrap and range-error corners.
module tb_atomic_counter_bank;
`ifdef ATOMIC_CNT_CLR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] trig_a = '0;
  logic [4:0] trig_b = '0;

  atomic_counter_bank_if #(.SEL_W(2), .WRD_W(1), .BUS_W(32)) ia ();
  atomic_counter_bank_if #(.SEL_W(3), .WRD_W(2), .BUS_W(4))  ib ();

  atomic_counter_bank #(.NUM_CNT(4), .CNT_W(64), .BUS_W(32)) dut_a (
    .clk(clk), .reset_n(rst_n), .trig_i(trig_a), .bus(ia));
  atomic_counter_bank #(.NUM_CNT(5), .CNT_W(12), .BUS_W(4)) dut_b (
    .clk(clk), .reset_n(rst_n), .trig_i(trig_b), .bus(ib));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the default build: full-width counters and the snapshotted upper word.
  logic [63:0] m_cnt [4];
  logic [31:0] m_shd [4];
  logic        e_ack = 1'b0, e_err = 1'b0;
  logic [31:0] e_cnt = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    chk_en <= 1'b1;
    if (!rst_n) begin
      e_ack <= 1'b0; e_err <= 1'b0; e_cnt <= '0;
      for (int c = 0; c < 4; c++) begin m_cnt[c] <= '0; m_shd[c] <= '0; end
    end else begin
      e_ack <= ia.req_i;
      e_err <= ia.req_i && ia.atomic_i && (ia.word_i != 1'b0);
      e_cnt <= '0;
      if (ia.req_i && !(ia.atomic_i && (ia.word_i != 1'b0))) begin
        if (ia.word_i == 1'b0) begin
          e_cnt <= m_cnt[ia.sel_i][31:0];
          if (ia.atomic_i) m_shd[ia.sel_i] <= m_cnt[ia.sel_i][63:32];
        end else begin
          e_cnt <= m_shd[ia.sel_i];
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (CLR && ia.req_i && ia.atomic_i && (ia.word_i == 1'b0) && (ia.sel_i == 2'(c)))
          m_cnt[c] <= 64'(trig_a[c]);
        else
          m_cnt[c] <= m_cnt[c] + 64'(trig_a[c]);
      end
    end
  end

  always @(negedge clk)
    if (chk_en) chk("model", {30'b0, ia.ack_o, ia.err_o, ia.count_o}, {30'b0, e_ack, e_err, e_cnt});

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rd_a(input logic [1:0] s, input logic w, input logic at);
    ia.req_i = 1'b1; ia.sel_i = s; ia.word_i = w; ia.atomic_i = at;
    cyc(1);
    ia.req_i = 1'b0; ia.atomic_i = 1'b0;
  endtask

  task automatic rd_b(input logic [2:0] s, input logic [1:0] w, input logic at);
    ib.req_i = 1'b1; ib.sel_i = s; ib.word_i = w; ib.atomic_i = at;
    cyc(1);
    ib.req_i = 1'b0; ib.atomic_i = 1'b0;
  endtask

  task automatic lit_a(input string nm, input logic e, input logic [31:0] v);
    chk(nm, {30'b0, ia.ack_o, ia.err_o, ia.count_o}, {30'b0, 1'b1, e, v});
  endtask

  task automatic lit_b(input string nm, input logic e, input logic [3:0] v);
    chk(nm, {58'b0, ib.ack_o, ib.err_o, ib.count_o}, {58'b0, 1'b1, e, v});
  endtask

  logic [31:0] b2b_exp [4];

  initial begin
    ia.req_i = 1'b0; ia.atomic_i = 1'b0; ia.sel_i = '0; ia.word_i = '0;
    ib.req_i = 1'b0; ib.atomic_i = 1'b0; ib.sel_i = '0; ib.word_i = '0;
    rst_n = 1'b0;
    cyc(3);
    chk("reset a", {ia.ack_o, ia.err_o, ia.count_o}, '0);
    chk("reset b", {ib.ack_o, ib.err_o, ib.count_o}, '0);
    rst_n = 1'b1;
    cyc(1);

    trig_a[0] = 1'b1; cyc(5); trig_a[0] = 1'b0;
    rd_a(0, 0, 0); lit_a("ch0 five", 1'b0, 32'd5);
    cyc(1); chk("ack one cycle", ia.ack_o, 0);

    // Atomic read lands on the same edge as an increment.
    trig_a[1] = 1'b1; cyc(9);
    rd_a(1, 0, 1); trig_a[1] = 1'b0;
    lit_a("ch1 atomic trig", 1'b0, 32'd9);
    rd_a(1, 1, 0); lit_a("ch1 shadow", 1'b0, 32'd0);

    trig_a[2] = 1'b1; trig_a[3] = 1'b1; cyc(3);
    trig_a[2] = 1'b0; cyc(4); trig_a[3] = 1'b0;

    b2b_exp[0] = 32'd5; b2b_exp[1] = CLR ? 32'd1 : 32'd10;
    b2b_exp[2] = 32'd3; b2b_exp[3] = 32'd7;
    for (int i = 0; i < 4; i++) begin
      ia.req_i = 1'b1; ia.sel_i = 2'(i); ia.word_i = 1'b0; ia.atomic_i = 1'b0;
      cyc(1);
      lit_a($sformatf("b2b ch%0d", i), 1'b0, b2b_exp[i]);
    end
    ia.req_i = 1'b0;

    rd_a(2, 1, 1); lit_a("atomic word1 err", 1'b1, 32'd0);
    ia.atomic_i = 1'b1; cyc(1); ia.atomic_i = 1'b0;
    chk("atomic no req", ia.ack_o, 0);

    trig_a[3] = 1'b1; rd_a(3, 0, 1); trig_a[3] = 1'b0;
    lit_a("ch3 atomic", 1'b0, 32'd7);
    rd_a(3, 0, 0); lit_a("ch3 after", 1'b0, CLR ? 32'd1 : 32'd8);

    // Scaled carry case: ch2 at 0x01F while counting every cycle.
    trig_b[2] = 1'b1; cyc(31);
    rd_b(2, 0, 1); lit_b("b ch2 lo", 1'b0, 4'hF);
    cyc(2);
    rd_b(2, 1, 0); lit_b("b ch2 w1", 1'b0, 4'h1);
    trig_b[2] = 1'b0;
    rd_b(2, 2, 0); lit_b("b ch2 w2", 1'b0, 4'h0);

    rd_b(5, 0, 0); lit_b("b sel5 err", 1'b1, 4'h0);
    rd_b(4, 3, 0); lit_b("b word3 err", 1'b1, 4'h0);
    rd_b(2, 1, 1); lit_b("b atomic w1 err", 1'b1, 4'h0);
    rd_b(2, 1, 0); lit_b("b shadow kept", 1'b0, 4'h1);
    rd_b(4, 2, 0); lit_b("b sel4 legal", 1'b0, 4'h0);

    trig_b[0] = 1'b1; cyc(4095); trig_b[0] = 1'b0;
    rd_b(0, 0, 0); lit_b("b max lo", 1'b0, 4'hF);
    rd_b(0, 0, 1); lit_b("b max atomic", 1'b0, 4'hF);
    rd_b(0, 1, 0); lit_b("b max w1", 1'b0, 4'hF);
    rd_b(0, 2, 0); lit_b("b max w2", 1'b0, 4'hF);
    trig_b[0] = 1'b1; cyc(1); trig_b[0] = 1'b0;
    rd_b(0, 0, 1); lit_b("b wrap lo", 1'b0, CLR ? 4'h1 : 4'h0);
    rd_b(0, 1, 0); lit_b("b wrap w1", 1'b0, 4'h0);
    rd_b(0, 2, 0); lit_b("b wrap w2", 1'b0, 4'h0);

    // Request in the reset cycle must be dropped.
    ia.req_i = 1'b1; ia.sel_i = 2'd0; ia.word_i = 1'b0;
    ib.req_i = 1'b1; ib.sel_i = 3'd2; ib.word_i = 2'd1;
    rst_n = 1'b0;
    cyc(1);
    ia.req_i = 1'b0; ib.req_i = 1'b0;
    chk("reset req a", {ia.ack_o, ia.err_o, ia.count_o}, '0);
    chk("reset req b", {ib.ack_o, ib.err_o, ib.count_o}, '0);
    cyc(1);
    chk("reset drop ack", ia.ack_o, 0);
    rst_n = 1'b1;
    rd_a(0, 0, 0); lit_a("ch0 after reset", 1'b0, 32'd0);
    rd_b(2, 1, 0); lit_b("b shadow after reset", 1'b0, 4'h0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
